// File: rtl/bus_cycle_timer_pkg.sv
// Shared constants for the bus cycle timer: bus device IDs and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bus_cycle_timer_pkg;

  localparam int BUS_DEVICE_ID_WIDTH = 3;

  typedef logic [BUS_DEVICE_ID_WIDTH-1:0] dev_id_t;

  localparam dev_id_t SRAM_ID          = 3'd1;
  localparam dev_id_t UART_ID          = 3'd2;
  localparam dev_id_t SPI_ID           = 3'd3;
  localparam dev_id_t CLOCK_SCALER_ID  = 3'd4;
  localparam dev_id_t CYCLE_COUNTER_ID = 3'd5;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HIGH    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

endpackage

// File: rtl/bus_cycle_timer_phase_counter.sv
// Loadable down-counter with a terminal-count (zero) flag; used for phase and stretch timing.
// Latency: load/decrement take effect on the next clk; zero reflects the registered count.
// Backpressure: none; load has priority over dec, count holds when neither is asserted.
//   clk, reset_n        : clock, async active-low reset
//   load, load_val      : synchronous load of a new count
//   dec                 : decrement by one
//   zero                : count is zero
module bus_cycle_timer_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/bus_cycle_timer.sv
// Generates phi2 and sequences LOW/HIGH/STRETCH/HALT bus phases with per-device HIGH stretching.
// Latency: all outputs registered; each phase lasts divisor+1 clk (HIGH adds SRAM waits/stretch).
// Backpressure: device_ready=0 holds HIGH up to STRETCH_LIMIT clk; run=0 parks in HALT until run/step.
//   clk, reset_n                     : master clock, async active-low reset
//   run, step                        : free-run / single-cycle permission
//   divisor, sram_wait               : phase length and extra SRAM HIGH ticks (sampled at phase entry)
//   active_bus_device_id, device_ready : decoder result and device handshake
//   phi2, phi2_rise, phi2_fall       : CPU clock and its edge pulses
//   halted, bus_timeout, cycle_device_id : status outputs
module bus_cycle_timer
  import bus_cycle_timer_pkg::*;
#(
  parameter int          DIV_WIDTH     = 8,
  parameter int          WAIT_WIDTH    = 4,
  parameter int unsigned STRETCH_LIMIT = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic                           step,
  input  logic [DIV_WIDTH-1:0]           divisor,
  input  logic [WAIT_WIDTH-1:0]          sram_wait,
  input  logic [BUS_DEVICE_ID_WIDTH-1:0] active_bus_device_id,
  input  logic                           device_ready,
  output logic                           phi2,
  output logic                           phi2_rise,
  output logic                           phi2_fall,
  output logic                           halted,
  output logic                           bus_timeout,
  output logic [BUS_DEVICE_ID_WIDTH-1:0] cycle_device_id
);

  // HIGH length (divisor + SRAM waits) needs one extra bit so it never wraps.
  localparam int CW = DIV_WIDTH + 1;
  localparam int SW = $clog2(STRETCH_LIMIT + 1);
  localparam logic [SW-1:0] ST_LOAD = SW'(STRETCH_LIMIT - 1);

  state_t          state_q, state_d;
  logic            first_q;
  logic            go;
  logic [CW-1:0]   high_len;
  logic            ph_load, ph_dec, ph_zero;
  logic [CW-1:0]   ph_load_val;
  logic            st_load, st_dec, st_zero;
  logic            phi2_d, rise_d, fall_d, halted_d, tmo_d, id_lat;

  assign go = run | step;

  // The device ID is latched on the same edge HIGH is entered, so the SRAM
  // test looks at the decoder output directly rather than cycle_device_id.
  assign high_len = CW'(divisor) +
                    ((active_bus_device_id == SRAM_ID) ? CW'(sram_wait) : '0);

  bus_cycle_timer_phase_counter #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ph_load),
    .load_val (ph_load_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  bus_cycle_timer_phase_counter #(.W(SW)) u_stretch_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (st_load),
    .load_val (ST_LOAD),
    .dec      (st_dec),
    .zero     (st_zero)
  );

  always_comb begin
    state_d     = state_q;
    ph_load     = 1'b0;
    ph_dec      = 1'b0;
    ph_load_val = high_len;
    st_load     = 1'b0;
    st_dec      = 1'b0;
    phi2_d      = phi2;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    halted_d    = halted;
    tmo_d       = 1'b0;
    id_lat      = 1'b0;

    case (state_q)
      ST_LOW: begin
        // The first LOW after reset has no preloaded count: this tick
        // samples divisor itself and counts as tick one.
        if (first_q ? (divisor == '0) : ph_zero) begin
          id_lat = 1'b1;
          if (go) begin
            state_d = ST_HIGH;
            phi2_d  = 1'b1;
            rise_d  = 1'b1;
            ph_load = 1'b1;
          end else begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end else if (first_q) begin
          ph_load     = 1'b1;
          ph_load_val = CW'(divisor) - CW'(1);
        end else begin
          ph_dec = 1'b1;
        end
      end

      ST_HALT: begin
        id_lat = 1'b1;
        if (go) begin
          state_d  = ST_HIGH;
          phi2_d   = 1'b1;
          rise_d   = 1'b1;
          halted_d = 1'b0;
          ph_load  = 1'b1;
        end
      end

      ST_HIGH: begin
        if (!ph_zero) begin
          ph_dec = 1'b1;
        end else if (device_ready) begin
          state_d     = ST_LOW;
          phi2_d      = 1'b0;
          fall_d      = 1'b1;
          ph_load     = 1'b1;
          ph_load_val = CW'(divisor);
        end else begin
          state_d = ST_STRETCH;
          st_load = 1'b1;
        end
      end

      ST_STRETCH: begin
        // A ready on the final stretch tick is a normal end, not a timeout.
        if (device_ready || st_zero) begin
          state_d     = ST_LOW;
          phi2_d      = 1'b0;
          fall_d      = 1'b1;
          tmo_d       = !device_ready;
          ph_load     = 1'b1;
          ph_load_val = CW'(divisor);
        end else begin
          st_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_LOW;
        phi2_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_LOW;
      first_q         <= 1'b1;
      phi2            <= 1'b0;
      phi2_rise       <= 1'b0;
      phi2_fall       <= 1'b0;
      halted          <= 1'b0;
      bus_timeout     <= 1'b0;
      cycle_device_id <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= 1'b0;
      phi2        <= phi2_d;
      phi2_rise   <= rise_d;
      phi2_fall   <= fall_d;
      halted      <= halted_d;
      bus_timeout <= tmo_d;
      if (id_lat) begin
        cycle_device_id <= active_bus_device_id;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_timer.sv
module tb_bus_cycle_timer;
  import bus_cycle_timer_pkg::*;

  logic                           clk;
  logic                           reset_n;
  logic                           run;
  logic                           step;
  logic [7:0]                     divisor;
  logic [3:0]                     sram_wait;
  logic [BUS_DEVICE_ID_WIDTH-1:0] active_bus_device_id;
  logic                           device_ready;
  logic                           phi2;
  logic                           phi2_rise;
  logic                           phi2_fall;
  logic                           halted;
  logic                           bus_timeout;
  logic [BUS_DEVICE_ID_WIDTH-1:0] cycle_device_id;

  int total = 0;
  int bad   = 0;

  bus_cycle_timer #(
    .DIV_WIDTH     (8),
    .WAIT_WIDTH    (4),
    .STRETCH_LIMIT (255)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .run                  (run),
    .step                 (step),
    .divisor              (divisor),
    .sram_wait            (sram_wait),
    .active_bus_device_id (active_bus_device_id),
    .device_ready         (device_ready),
    .phi2                 (phi2),
    .phi2_rise            (phi2_rise),
    .phi2_fall            (phi2_fall),
    .halted               (halted),
    .bus_timeout          (bus_timeout),
    .cycle_device_id      (cycle_device_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next sample showing phi2_rise; n = samples waited.
  task automatic wait_rise(input string tag, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!phi2_rise && n < limit);
    chk(tag, 32'(phi2_rise), 32'd1);
  endtask

  // Measure one phi2 period starting at a rise sample, ending at the next
  // rise sample. device_ready is held 0 for the first ready_lo HIGH clks.
  task automatic meas(input int ready_lo, output int hi, output int lo,
                      output int nr, output int nf, output int nt);
    int budget;
    hi = 0; lo = 0; nr = 0; nf = 0; nt = 0; budget = 0;
    do begin
      if (phi2) hi++; else lo++;
      nr += 32'(phi2_rise);
      nf += 32'(phi2_fall);
      nt += 32'(bus_timeout);
      device_ready = phi2 ? (hi > ready_lo) : 1'b1;
      @(negedge clk);
      budget++;
    end while (!phi2_rise && budget < 2000);
    chk("meas_bound", 32'(phi2_rise), 32'd1);
  endtask

  task automatic count_rises(input int n, output int r);
    r = 32'(phi2_rise);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      r += 32'(phi2_rise);
    end
  endtask

  initial begin
    int n, hi, lo, nr, nf, nt, r;

    reset_n = 1'b0; run = 1'b1; step = 1'b0; divisor = 8'd1; sram_wait = 4'd0;
    active_bus_device_id = UART_ID; device_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_phi2", 32'(phi2), 32'd0);
    chk("rst_rise", 32'(phi2_rise), 32'd0);
    chk("rst_fall", 32'(phi2_fall), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(bus_timeout), 32'd0);
    chk("rst_devid", 32'(cycle_device_id), 32'd0);

    // divisor=1: first rise after divisor+1 LOW clk, then 4-clk period
    reset_n = 1'b1;
    wait_rise("first_rise", 100, n);
    chk("first_rise_lat", n, 2);
    chk("uart_devid", 32'(cycle_device_id), 32'(UART_ID));
    meas(0, hi, lo, nr, nf, nt);
    chk("div1_hi", hi, 2);
    chk("div1_lo", lo, 2);
    chk("div1_rises", nr, 1);
    chk("div1_falls", nf, 1);
    chk("div1_tmo", nt, 0);

    // SRAM wait states: divisor=0, sram_wait=3 -> HIGH 4, LOW 1
    divisor = 8'd0; sram_wait = 4'd3; active_bus_device_id = SRAM_ID;
    meas(0, hi, lo, nr, nf, nt);
    chk("sram_devid", 32'(cycle_device_id), 32'(SRAM_ID));
    // Mid-HIGH changes must not affect the cycle in progress.
    active_bus_device_id = UART_ID; sram_wait = 4'd7;
    meas(0, hi, lo, nr, nf, nt);
    chk("sram_hi", hi, 4);
    chk("sram_lo", lo, 1);
    meas(0, hi, lo, nr, nf, nt);
    chk("uart_hi", hi, 1);
    chk("uart_lo", lo, 1);

    // device_ready stretch: HIGH held for 11 clk, no timeout
    active_bus_device_id = SPI_ID;
    meas(0, hi, lo, nr, nf, nt);
    chk("spi_devid", 32'(cycle_device_id), 32'(SPI_ID));
    meas(10, hi, lo, nr, nf, nt);
    chk("stretch_hi", hi, 11);
    chk("stretch_tmo", nt, 0);
    chk("stretch_falls", nf, 1);

    // Stuck device: forced end after 1+255 HIGH clk, single timeout pulse
    meas(100000, hi, lo, nr, nf, nt);
    chk("timeout_hi", hi, 256);
    chk("timeout_pulses", nt, 1);
    chk("timeout_falls", nf, 1);
    meas(0, hi, lo, nr, nf, nt);
    chk("after_tmo_hi", hi, 1);
    chk("after_tmo_lo", lo, 1);
    chk("after_tmo_tmo", nt, 0);

    // Halt and single-step (divisor=3: 4-clk phases)
    divisor = 8'd3; run = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 20);
    chk("halt_entered", 32'(halted), 32'd1);
    chk("halt_phi2", 32'(phi2), 32'd0);
    @(negedge clk);
    count_rises(20, r);
    chk("halt_no_rise", r, 0);
    chk("halt_held", 32'(halted), 32'd1);

    step = 1'b1; @(negedge clk); step = 1'b0;
    chk("step1_rise", 32'(phi2_rise), 32'd1);
    chk("step1_unhalt", 32'(halted), 32'd0);
    count_rises(50, r);
    chk("step1_cycles", r, 1);
    chk("step1_rehalt", 32'(halted), 32'd1);

    step = 1'b1; @(negedge clk); step = 1'b0;
    chk("step2_rise", 32'(phi2_rise), 32'd1);
    // A step arriving during HIGH is dropped.
    @(negedge clk);
    step = 1'b1; @(negedge clk); step = 1'b0;
    count_rises(40, r);
    chk("step2_stray_dropped", r, 0);
    chk("step2_rehalt", 32'(halted), 32'd1);

    // Resume, then reset mid-HIGH
    divisor = 8'd2; run = 1'b1;
    wait_rise("resume_rise", 20, n);
    chk("resume_lat", n, 1);
    @(negedge clk);
    chk("pre_reset_phi2", 32'(phi2), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_phi2", 32'(phi2), 32'd0);
    chk("async_rst_devid", 32'(cycle_device_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_rise("post_rst_rise", 100, n);
    chk("post_rst_lat", n, 3);
    meas(0, hi, lo, nr, nf, nt);
    chk("post_rst_hi", hi, 3);
    chk("post_rst_lo", lo, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
